// File: rtl/mips_pkg.sv
// Shared types and constants for the multicycle MIPS memory subsystem.
package mips_pkg;
  localparam int RAM_WORDS  = 128;
  localparam int DEBUG_BASE = 64;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} arb_state_t;
  typedef enum logic {REQ_CPU = 1'b0, REQ_DBG = 1'b1} requester_t;
endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker; req bit index equals the requester_t encoding.
module rr_pick2
  import mips_pkg::*;
(
  input  logic [1:0] req,
  input  requester_t last,
  output logic       gnt_valid,
  output requester_t gnt_id
);
  always_comb begin
    gnt_valid = |req;
    gnt_id    = REQ_CPU;
    if (req == 2'b11)
      gnt_id = (last == REQ_CPU) ? REQ_DBG : REQ_CPU;
    else if (req[1])
      gnt_id = REQ_DBG;
  end
endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates the unified MIPS RAM between the CPU datapath and the debug/loader port.
module ram_arbiter
  import mips_pkg::*;
#(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_ready,
  input  logic              dbg_halt,
  output logic              cpu_halted,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);
  arb_state_t        state_q, state_d;
  requester_t        gnt_q, gnt_d, last_q, last_d, pick_id;
  logic              pick_valid;
  logic              acc_we_q, acc_we_d;
  logic              ram_en_q, ram_en_d, ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic              cpu_halted_q, cpu_halted_d;
  logic              cpu_busy, resp;

  // Halt masks the CPU combinationally so a same-cycle halt blocks the grant.
  rr_pick2 u_pick (
    .req      ({dbg_req, cpu_req & ~dbg_halt}),
    .last     (last_q),
    .gnt_valid(pick_valid),
    .gnt_id   (pick_id)
  );

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    last_d      = last_q;
    acc_we_d    = acc_we_q;
    ram_en_d    = ram_en_q;
    ram_we_d    = ram_we_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    case (state_q)
      IDLE: begin
        ram_en_d = 1'b0;
        ram_we_d = 1'b0;
        if (pick_valid) begin
          state_d     = ISSUE;
          gnt_d       = pick_id;
          last_d      = pick_id;
          ram_en_d    = 1'b1;
          ram_we_d    = (pick_id == REQ_DBG) ? dbg_we    : cpu_we;
          ram_addr_d  = (pick_id == REQ_DBG) ? dbg_addr  : cpu_addr;
          ram_wdata_d = (pick_id == REQ_DBG) ? dbg_wdata : cpu_wdata;
          acc_we_d    = ram_we_d;
        end
      end
      ISSUE: begin
        state_d  = RESP;
        ram_en_d = 1'b0;
        ram_we_d = 1'b0;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign cpu_busy     = (state_q != IDLE) && (gnt_q == REQ_CPU);
  assign cpu_halted_d = dbg_halt && !cpu_busy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      gnt_q        <= REQ_DBG;
      last_q       <= REQ_DBG;
      acc_we_q     <= 1'b0;
      ram_en_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      cpu_halted_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      last_q       <= last_d;
      acc_we_q     <= acc_we_d;
      ram_en_q     <= ram_en_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      cpu_halted_q <= cpu_halted_d;
    end
  end

  // Read data is a pass-through of the RAM port, only exposed for completed reads.
  assign resp       = (state_q == RESP);
  assign cpu_ready  = resp && (gnt_q == REQ_CPU);
  assign dbg_ready  = resp && (gnt_q == REQ_DBG);
  assign cpu_rdata  = (cpu_ready && !acc_we_q) ? ram_rdata : '0;
  assign dbg_rdata  = (dbg_ready && !acc_we_q) ? ram_rdata : '0;
  assign cpu_halted = cpu_halted_q;
  assign ram_en     = ram_en_q;
  assign ram_we     = ram_we_q;
  assign ram_addr   = ram_addr_q;
  assign ram_wdata  = ram_wdata_q;
endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_ram_arbiter;
  localparam int AW = 7;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_we, dbg_req, dbg_we, dbg_halt;
  logic [AW-1:0] cpu_addr, dbg_addr, ram_addr;
  logic [DW-1:0] cpu_wdata, dbg_wdata, cpu_rdata, dbg_rdata, ram_wdata, ram_rdata;
  logic          cpu_ready, dbg_ready, cpu_halted, ram_en, ram_we;
  logic          preload;
  logic [DW-1:0] mem [0:127];
  int            total = 0;
  int            bad   = 0;

  always #5 clk = ~clk;

  // Synchronous RAM: samples on the edge, data appears the following cycle.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 128; i++) mem[i] <= 32'h0100_0000 + 32'(i);
      mem[0]  <= 32'h2019_0040;
      mem[1]  <= 32'h0000_8020;
      mem[10] <= 32'hA5A5_A5A5;
    end else if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
    end
  end

  ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata), .dbg_ready(dbg_ready),
    .dbg_halt(dbg_halt), .cpu_halted(cpu_halted),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
    dbg_halt = 0;
  endtask

  task automatic do_reset();
    rst = 0; idle_inputs();
    cyc(); cyc();
    rst = 1;
  endtask

  task automatic test_reset();
    rst = 0; cpu_req = 1; cpu_addr = 7'd3;
    cyc(); #1;
    total++; if (ram_en !== 1'b0) begin bad++; $display("FAIL reset_ram_en got=%b want=0", ram_en); end
    total++; if (ram_we !== 1'b0) begin bad++; $display("FAIL reset_ram_we got=%b want=0", ram_we); end
    total++; if (ram_addr !== 7'd0) begin bad++; $display("FAIL reset_ram_addr got=%h want=0", ram_addr); end
    total++; if (ram_wdata !== 32'd0) begin bad++; $display("FAIL reset_ram_wdata got=%h want=0", ram_wdata); end
    total++; if ({cpu_ready, dbg_ready, cpu_halted} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", {cpu_ready, dbg_ready, cpu_halted}); end
    total++; if (cpu_rdata !== 32'd0 || dbg_rdata !== 32'd0) begin bad++; $display("FAIL reset_rdata got=%h/%h want=0/0", cpu_rdata, dbg_rdata); end
    idle_inputs();
    cyc(); rst = 1;
  endtask

  task automatic test_dbg_write_cpu_read();
    cyc();
    dbg_req = 1; dbg_we = 1; dbg_addr = 7'd79; dbg_wdata = 32'd5;
    cyc();
    total++; if ({ram_en, ram_we} !== 2'b11 || ram_addr !== 7'd79 || ram_wdata !== 32'd5) begin bad++; $display("FAIL dw_issue got en/we=%b%b addr=%0d data=%h want 11/79/5", ram_en, ram_we, ram_addr, ram_wdata); end
    total++; if (dbg_ready !== 1'b0) begin bad++; $display("FAIL dw_early_ready got=%b want=0", dbg_ready); end
    cyc();
    total++; if (dbg_ready !== 1'b1 || cpu_ready !== 1'b0) begin bad++; $display("FAIL dw_ready got dbg=%b cpu=%b want 1/0", dbg_ready, cpu_ready); end
    total++; if (dbg_rdata !== 32'd0 || ram_en !== 1'b0) begin bad++; $display("FAIL dw_resp got rdata=%h en=%b want 0/0", dbg_rdata, ram_en); end
    dbg_req = 0; dbg_we = 0;
    cyc();
    total++; if (mem[79] !== 32'd5) begin bad++; $display("FAIL dw_mem got=%h want=5", mem[79]); end
    cpu_req = 1; cpu_we = 0; cpu_addr = 7'd79;
    cyc();
    total++; if (cpu_ready !== 1'b0) begin bad++; $display("FAIL cr_early got=%b want=0", cpu_ready); end
    cyc();
    total++; if (cpu_ready !== 1'b1 || cpu_rdata !== 32'd5 || dbg_rdata !== 32'd0) begin bad++; $display("FAIL cr_ready got rdy=%b rdata=%h other=%h want 1/5/0", cpu_ready, cpu_rdata, dbg_rdata); end
    cpu_req = 0;
    cyc();
  endtask

  task automatic test_simultaneous();
    do_reset();
    cpu_req = 1; cpu_we = 0; cpu_addr = 7'd0;
    dbg_req = 1; dbg_we = 0; dbg_addr = 7'd1;
    cyc();
    total++; if (ram_en !== 1'b1 || ram_addr !== 7'd0) begin bad++; $display("FAIL sim_first got en=%b addr=%0d want 1/0", ram_en, ram_addr); end
    cyc();
    total++; if (cpu_ready !== 1'b1 || dbg_ready !== 1'b0 || cpu_rdata !== 32'h2019_0040) begin bad++; $display("FAIL sim_cpu got c=%b d=%b rdata=%h want 1/0/20190040", cpu_ready, dbg_ready, cpu_rdata); end
    cpu_req = 0;
    cyc();
    total++; if (ram_en !== 1'b0) begin bad++; $display("FAIL sim_gap got en=%b want=0", ram_en); end
    cyc();
    total++; if (ram_en !== 1'b1 || ram_addr !== 7'd1) begin bad++; $display("FAIL sim_dbg_issue got en=%b addr=%0d want 1/1", ram_en, ram_addr); end
    cyc();
    total++; if (dbg_ready !== 1'b1 || cpu_ready !== 1'b0 || dbg_rdata !== 32'h0000_8020) begin bad++; $display("FAIL sim_dbg got d=%b c=%b rdata=%h want 1/0/00008020", dbg_ready, cpu_ready, dbg_rdata); end
    dbg_req = 0;
    cyc();
  endtask

  task automatic test_back_to_back();
    logic ec, ed;
    cpu_req = 1; cpu_we = 0; cpu_addr = 7'd0;
    dbg_req = 1; dbg_we = 0; dbg_addr = 7'd1;
    for (int k = 1; k <= 18; k++) begin
      cyc();
      ec = (k % 3 == 2) && ((k / 3) % 2 == 0);
      ed = (k % 3 == 2) && ((k / 3) % 2 == 1);
      total++; if (cpu_ready !== ec || dbg_ready !== ed) begin bad++; $display("FAIL b2b_order k=%0d got c=%b d=%b want c=%b d=%b", k, cpu_ready, dbg_ready, ec, ed); end
      if (ec) begin
        total++; if (cpu_rdata !== 32'h2019_0040) begin bad++; $display("FAIL b2b_cpu_data k=%0d got=%h want=20190040", k, cpu_rdata); end
      end
      if (ed) begin
        total++; if (dbg_rdata !== 32'h0000_8020) begin bad++; $display("FAIL b2b_dbg_data k=%0d got=%h want=00008020", k, dbg_rdata); end
      end
      if (k == 17) begin cpu_req = 0; dbg_req = 0; end
    end
  endtask

  task automatic test_halt();
    bit found;
    cpu_req = 1; cpu_we = 0; cpu_addr = 7'd79;
    cyc();
    total++; if (ram_en !== 1'b1 || ram_addr !== 7'd79) begin bad++; $display("FAIL halt_issue got en=%b addr=%0d want 1/79", ram_en, ram_addr); end
    dbg_halt = 1;
    cyc();
    total++; if (cpu_ready !== 1'b1 || cpu_rdata !== 32'd5 || cpu_halted !== 1'b0) begin bad++; $display("FAIL halt_inflight got rdy=%b rdata=%h halted=%b want 1/5/0", cpu_ready, cpu_rdata, cpu_halted); end
    cpu_req = 0;
    cyc();
    total++; if (cpu_halted !== 1'b0) begin bad++; $display("FAIL halt_early got=%b want=0", cpu_halted); end
    cpu_req = 1; cpu_we = 0; cpu_addr = 7'd0;
    dbg_req = 1; dbg_we = 1; dbg_addr = 7'd66; dbg_wdata = 32'hDEAD_BEEF;
    cyc();
    total++; if (cpu_halted !== 1'b1) begin bad++; $display("FAIL halt_set got=%b want=1", cpu_halted); end
    total++; if (ram_en !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 7'd66) begin bad++; $display("FAIL halt_dbg_issue got en=%b we=%b addr=%0d want 1/1/66", ram_en, ram_we, ram_addr); end
    cyc();
    total++; if (dbg_ready !== 1'b1 || cpu_ready !== 1'b0) begin bad++; $display("FAIL halt_dbg_ready got d=%b c=%b want 1/0", dbg_ready, cpu_ready); end
    dbg_req = 0; dbg_we = 0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      total++; if (cpu_ready !== 1'b0 || ram_en !== 1'b0 || cpu_halted !== 1'b1) begin bad++; $display("FAIL halt_hold i=%0d got rdy=%b en=%b halted=%b want 0/0/1", i, cpu_ready, ram_en, cpu_halted); end
    end
    total++; if (mem[66] !== 32'hDEAD_BEEF) begin bad++; $display("FAIL halt_mem got=%h want=deadbeef", mem[66]); end
    dbg_halt = 0;
    found = 0;
    for (int i = 0; i < 2 && !found; i++) begin
      cyc();
      if (ram_en === 1'b1 && ram_addr === 7'd0) found = 1;
    end
    total++; if (!found) begin bad++; $display("FAIL unhalt_grant got=none want=cpu grant within 2 cycles"); end
    total++; if (cpu_halted !== 1'b0) begin bad++; $display("FAIL unhalt_flag got=%b want=0", cpu_halted); end
    cyc();
    total++; if (cpu_ready !== 1'b1 || cpu_rdata !== 32'h2019_0040) begin bad++; $display("FAIL unhalt_ready got rdy=%b rdata=%h want 1/20190040", cpu_ready, cpu_rdata); end
    cpu_req = 0;
    cyc();
  endtask

  task automatic test_reset_mid_write();
    cpu_req = 1; cpu_we = 1; cpu_addr = 7'd10; cpu_wdata = 32'h1234_5678;
    cyc();
    total++; if (ram_en !== 1'b1 || ram_we !== 1'b1) begin bad++; $display("FAIL rmw_issue got en=%b we=%b want 1/1", ram_en, ram_we); end
    rst = 0;
    #1;
    total++; if (ram_en !== 1'b0 || ram_we !== 1'b0 || cpu_ready !== 1'b0) begin bad++; $display("FAIL rmw_abort got en=%b we=%b rdy=%b want 0/0/0", ram_en, ram_we, cpu_ready); end
    idle_inputs();
    cyc();
    total++; if (cpu_ready !== 1'b0) begin bad++; $display("FAIL rmw_noready got=%b want=0", cpu_ready); end
    rst = 1;
    cyc(); cyc();
    total++; if (mem[10] !== 32'hA5A5_A5A5) begin bad++; $display("FAIL rmw_mem got=%h want=a5a5a5a5", mem[10]); end
    total++; if (cpu_ready !== 1'b0 || dbg_ready !== 1'b0) begin bad++; $display("FAIL rmw_quiet got c=%b d=%b want 0/0", cpu_ready, dbg_ready); end
  endtask

  // Model: an access decided in cycle g drives ram_en in g+1, ready in g+2, and
  // the port is free for a new decision from g+3. Data comes from a shadow memory.
  task automatic test_random();
    logic [DW-1:0] shadow [0:127];
    int g = -10, free_at = 0, port = 0, last = 1;
    logic act = 0, halt_exp = 0, a_we = 0, ec, ed, cpu_infl;
    logic [AW-1:0] a_addr = '0;
    logic [DW-1:0] exp_rd = '0;
    do_reset();
    for (int i = 0; i < 128; i++) shadow[i] = mem[i];
    for (int c = 0; c < 400; c++) begin
      ec = act && c == g + 2 && port == 0;
      ed = act && c == g + 2 && port == 1;
      total++; if (cpu_ready !== ec || dbg_ready !== ed) begin bad++; $display("FAIL rnd_ready c=%0d got c=%b d=%b want c=%b d=%b", c, cpu_ready, dbg_ready, ec, ed); end
      if (ec) begin
        total++; if (cpu_rdata !== exp_rd) begin bad++; $display("FAIL rnd_cpu_rdata c=%0d got=%h want=%h", c, cpu_rdata, exp_rd); end
      end
      if (ed) begin
        total++; if (dbg_rdata !== exp_rd) begin bad++; $display("FAIL rnd_dbg_rdata c=%0d got=%h want=%h", c, dbg_rdata, exp_rd); end
      end
      total++; if (ram_en !== (act && c == g + 1)) begin bad++; $display("FAIL rnd_ram_en c=%0d got=%b want=%b", c, ram_en, act && c == g + 1); end
      if (act && c == g + 1) begin
        total++; if (ram_addr !== a_addr || ram_we !== a_we) begin bad++; $display("FAIL rnd_ram_cmd c=%0d got addr=%0d we=%b want %0d/%b", c, ram_addr, ram_we, a_addr, a_we); end
      end
      total++; if (cpu_halted !== halt_exp) begin bad++; $display("FAIL rnd_halted c=%0d got=%b want=%b", c, cpu_halted, halt_exp); end
      // environment: requesters hold until they see ready, then may request again
      if (cpu_ready) cpu_req = 0;
      if (dbg_ready) dbg_req = 0;
      if (!cpu_req && $urandom_range(0, 1) == 1) begin
        cpu_req = 1; cpu_we = 1'($urandom_range(0, 1));
        cpu_addr = 7'($urandom_range(0, 127)); cpu_wdata = $urandom;
      end
      if (!dbg_req && $urandom_range(0, 1) == 1) begin
        dbg_req = 1; dbg_we = 1'($urandom_range(0, 1));
        dbg_addr = 7'($urandom_range(0, 127)); dbg_wdata = $urandom;
      end
      if ($urandom_range(0, 15) == 0) dbg_halt = ~dbg_halt;
      cpu_infl = act && port == 0 && (c == g + 1 || c == g + 2);
      halt_exp = dbg_halt && !cpu_infl;
      if (c >= free_at) begin
        ec = cpu_req && !dbg_halt;
        ed = dbg_req;
        if (ec || ed) begin
          port = (ec && ed) ? ((last == 0) ? 1 : 0) : (ed ? 1 : 0);
          a_we   = (port == 1) ? dbg_we : cpu_we;
          a_addr = (port == 1) ? dbg_addr : cpu_addr;
          exp_rd = a_we ? '0 : shadow[a_addr];
          if (a_we) shadow[a_addr] = (port == 1) ? dbg_wdata : cpu_wdata;
          g = c; free_at = c + 3; act = 1; last = port;
        end
      end
      cyc();
    end
    idle_inputs();
    cyc(); cyc(); cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 0; idle_inputs(); preload = 1;
    cyc(); cyc();
    preload = 0;
    test_reset();
    test_dbg_write_cpu_read();
    test_simultaneous();
    test_back_to_back();
    test_halt();
    test_reset_mid_write();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single unified instruction/data RAM (128 x 32-bit words) of the multicycle MIPS between two requesters.
- Requester 1 is the CPU datapath memory port. Requester 2 is the debug/loader port, which loads programs and inspects memory via sw_addr.
- Sits between the datapath and the RAM instance. Round-robin arbitrates contending accesses, enforces a req/ready handshake and can halt the CPU port for exclusive debug access.
- All RAM control outputs are registered. The RAM is synchronous: it samples en/we/addr/wdata on the clock edge and returns rdata one cycle later.

Parameters:
- ADDR_W, 7, word address width (128 words).
- DATA_W, 32, data word width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU access request; held until cpu_ready.
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req.
- cpu_addr  in  ADDR_W  CPU word address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_rdata  out  DATA_W  read data; valid only while cpu_ready=1.
- cpu_ready  out  1  single-cycle completion pulse for the CPU.
- dbg_req  in  1  debug access request; held until dbg_ready.
- dbg_we  in  1  debug write enable.
- dbg_addr  in  ADDR_W  debug word address.
- dbg_wdata  in  DATA_W  debug write data.
- dbg_rdata  out  DATA_W  read data; valid only while dbg_ready=1.
- dbg_ready  out  1  single-cycle completion pulse for debug.
- dbg_halt  in  1  level; blocks new CPU grants while high.
- cpu_halted  out  1  CPU port frozen and no CPU access in flight.
- ram_en  out  1  RAM access strobe.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data, valid one cycle after the en edge.

Behaviour:
- FSM states: IDLE, ISSUE, RESP. Grant owner register gnt (CPU/DBG). last_grant register.
- Reset (rst=0, asynchronous):
  - state=IDLE, last_grant=DBG (so the CPU wins the first tie).
  - ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0.
  - cpu_ready=0, dbg_ready=0, cpu_halted=0, cpu_rdata=0, dbg_rdata=0.
- IDLE:
  - Eligible requesters are dbg_req, and cpu_req && !dbg_halt.
  - With exactly one eligible, grant it. With both eligible, grant the one not equal to last_grant.
  - On a grant: load ram_en=1, ram_we/addr/wdata from the winner, set gnt and last_grant, go to ISSUE.
  - With none eligible, stay in IDLE with ram_en=0.
- ISSUE: ram_en held high for exactly this cycle. Next state is RESP, and ram_en=0 and ram_we=0 are registered on that edge.
- RESP:
  - Ready of gnt pulses high for one cycle. Matching rdata = ram_rdata, passed through combinationally; rdata of the other port reads 0.
  - Next state is IDLE.
- Latency: a req seen in IDLE at cycle N produces ready at cycle N+2. The minimum re-request spacing is 3 cycles per access.
- Writes: the RAM is written on the ISSUE->RESP edge. Ready in RESP confirms the write. rdata is don't-care for writes and driven 0.
- Handshake violations: a requester that drops req before ready aborts nothing. The access completes, and its ready pulse is ignored by the requester.
- Halt:
  - cpu_halted register is set to 1 on the first edge where dbg_halt=1 and no CPU access is in ISSUE/RESP.
  - It clears on the edge after dbg_halt falls.
  - A CPU access already granted completes normally. Debug accesses are unaffected by halt.
- Fairness: under continuous contention, grants strictly alternate CPU, DBG, CPU, ...
- Reset mid-access: the in-flight access is abandoned and no ready is issued. A write is not performed if rst falls before the ISSUE->RESP edge.
- Simultaneous events:
  - dbg_halt rising in the same cycle a CPU request is eligible in IDLE blocks that CPU grant (halt evaluated combinationally in IDLE).

Decomposition:
- Shared package mips_pkg: typedef enum arb_state_t {IDLE, ISSUE, RESP}, typedef enum requester_t {REQ_CPU, REQ_DBG}, localparams RAM_WORDS=128 and DEBUG_BASE=64.
- One natural sub-module, rr_pick2: a combinational 2-way round-robin picker with inputs req[1:0] and last, and outputs gnt_valid and gnt_id. Everything else stays in ram_arbiter.

Test Plan:
- Debug write then CPU read:
  - dbg write addr 79 data 5; expect ram_en at N+1, dbg_ready at N+2, RAM[79]=5.
  - Then cpu read addr 79; expect cpu_ready 2 cycles later with cpu_rdata=5.
- Simultaneous requests after reset:
  - cpu read addr 0 (RAM=0x20190040) and dbg read addr 1 (RAM=0x00008020) both raised at once.
  - Expect CPU served first (cpu_rdata=0x20190040), then DBG (dbg_rdata=0x00008020), with the DBG grant starting the cycle after cpu_ready.
- Sustained contention over 6 accesses: expect grant order CPU,DBG,CPU,DBG,CPU,DBG, each access 3 cycles apart, and no ready on both ports in the same cycle.
- Halt:
  - dbg_halt=1 while a CPU read is in ISSUE; expect that read to complete, then cpu_halted=1.
  - A new cpu_req is never granted while the halt holds. A dbg write addr 66 data 0xDEADBEEF completes.
  - Dropping dbg_halt lets the pending CPU request be granted within 2 cycles.
- Reset mid-write:
  - cpu write addr 10 data 0x12345678 with rst pulled low during ISSUE before the edge.
  - Expect immediate ram_en=0 and cpu_ready=0, and RAM[10] unchanged after rst releases.
